// File: rtl/mem_bus_responder_pkg.sv
// mem_bus_responder_pkg: shared state codes and word layout for the memory request/response bus.
package mem_bus_responder_pkg;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {RSP_IDLE, RSP_WAIT, RSP_RESP} rsp_state_e;
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction
endpackage

// File: rtl/mem_bus_responder_resp_ram.sv
// resp_ram: single-port word store with bit-masked synchronous write and synchronous read.
module resp_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mask,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= (mem[idx] & ~mask) | (wdata & mask);
    if (re) rdata_q <= mem[idx];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: valid/ready memory target with WAIT_STATES latency and masked word access.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = WAIT_STATES > 1 ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(WORD_BYTES * DEPTH_WORDS);
  rsp_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d, err_q, err_d, load_q, load_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, mask_q, mask_d;
  logic              xfer, access, a_we, a_err;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_mask, ram_rdata;
  always_comb begin
    req_ready = (state_q == RSP_IDLE) || (state_q == RSP_RESP && rsp_ready);
    xfer      = req_valid && req_ready;
    access    = (state_q == RSP_WAIT && cnt_q <= CNT_W'(1)) || (xfer && WAIT_STATES == 0);
    // With zero wait states the access uses the request fields live on the accept edge
    a_we      = state_q == RSP_WAIT ? we_q : req_we;
    a_addr    = state_q == RSP_WAIT ? addr_q : req_addr;
    a_wdata   = state_q == RSP_WAIT ? wdata_q : req_wdata;
    a_mask    = state_q == RSP_WAIT ? mask_q : req_mask;
    a_err     = misaligned(a_addr[1:0]) || ({1'b0, a_addr} >= LIMIT);
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    err_d     = err_q;
    load_d    = load_q;
    if (state_q == RSP_RESP && rsp_ready) begin
      state_d = RSP_IDLE;
      err_d   = 1'b0;
      load_d  = 1'b0;
    end
    if (xfer) begin
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      mask_d  = req_mask;
      state_d = WAIT_STATES == 0 ? RSP_RESP : RSP_WAIT;
      cnt_d   = CNT_W'(WAIT_STATES);
    end
    if (state_q == RSP_WAIT) begin
      state_d = cnt_q <= CNT_W'(1) ? RSP_RESP : RSP_WAIT;
      cnt_d   = cnt_q - CNT_W'(1);
    end
    if (access) begin
      err_d  = a_err;
      load_d = !a_we && !a_err;
    end
  end
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RSP_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end
  resp_ram #(.DEPTH(DEPTH_WORDS), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_ram (
    .clk  (clk1),
    .we   (access && a_we && !a_err),
    .re   (access && !a_we && !a_err),
    .idx  (a_addr[2 +: IDX_W]),
    .wdata(a_wdata),
    .mask (a_mask),
    .rdata(ram_rdata)
  );
  assign rsp_valid = state_q == RSP_RESP;
  assign busy      = state_q != RSP_IDLE;
  assign rsp_err   = err_q;
  assign rsp_rdata = load_q ? ram_rdata : '0;
endmodule
